// File: rtl/fpro_bus_master.sv
// FPro bus master: command FIFO feeding an FSM that issues registered mmio
// write cycles and read bursts. Optional write acknowledge: FPRO_MASTER_WR_ACK_EN.
module fpro_bus_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [20:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        busy,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_RSP} state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          push, pop, empty, full;

  state_t        state, state_n;
  logic          next_cmd, launch_wr, launch_rd, capture;
  logic [20:0]   launch_addr;
  logic [20:0]   cur_addr;
  logic [3:0]    cur_len, beat;
`ifdef FPRO_MASTER_WR_ACK_EN
  logic          wr_ack;
`endif

  // ---------------- command FIFO ----------------
  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_L);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata, len: cmd_len};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    next_cmd    = 1'b0;
    pop         = 1'b0;
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;
    launch_addr = cur_addr;
    capture     = 1'b0;
`ifdef FPRO_MASTER_WR_ACK_EN
    wr_ack      = 1'b0;
`endif
    case (state)
      IDLE: next_cmd = 1'b1;
      WRITE: begin
`ifdef FPRO_MASTER_WR_ACK_EN
        wr_ack  = 1'b1;
        state_n = WAIT_RSP;
`else
        // no ack: chain straight into the next command for back-to-back writes
        next_cmd = 1'b1;
`endif
      end
      READ: begin
        capture = 1'b1;
        state_n = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_ready) begin
          if (rsp_last) next_cmd = 1'b1;
          else begin
            // next beat: only the register field advances, wrapping within the slot
            launch_rd   = 1'b1;
            launch_addr = {cur_addr[20:5], cur_addr[4:0] + 5'd1};
            state_n     = READ;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (next_cmd) begin
      if (!empty) begin
        pop         = 1'b1;
        launch_addr = head.addr;
        if (head.wr) begin
          launch_wr = 1'b1;
          state_n   = WRITE;
        end else begin
          launch_rd = 1'b1;
          state_n   = READ;
        end
      end else begin
        state_n = IDLE;
      end
    end
  end

  // ---------------- registered bus and response ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      cur_addr     <= '0;
      cur_len      <= '0;
      beat         <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_last     <= 1'b0;
    end else begin
      mmio_cs <= launch_wr || launch_rd;
      mmio_wr <= launch_wr;
      mmio_rd <= launch_rd;
      if (launch_wr || launch_rd) begin
        mmio_addr <= launch_addr;
        cur_addr  <= launch_addr;
      end
      if (launch_wr) mmio_wr_data <= head.wdata;
      if (pop) begin
        cur_len <= head.len;
        beat    <= '0;
      end else if (launch_rd) begin
        beat <= beat + 4'd1;
      end

      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mmio_rd_data;
        rsp_last  <= (beat == cur_len);
      end
`ifdef FPRO_MASTER_WR_ACK_EN
      else if (wr_ack) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_last  <= 1'b1;
      end
`endif
      else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
      end
    end
  end

  assign busy = !empty || (state != IDLE) || rsp_valid;

endmodule

// File: tb/tb_fpro_bus_master.sv
// Scoreboard bench for fpro_bus_master: commands are expanded into expected bus
// cycles and responses; a forked monitor compares what the DUT presents.
module tb_fpro_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_len;
  logic        rsp_valid, rsp_ready, rsp_last, busy;
  logic [31:0] rsp_rdata;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data;

  logic rdy_force = 1'b1, rdy_val = 1'b1, rdy_rand = 1'b1;

  always #5 clk = ~clk;

  fpro_bus_master #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .busy(busy),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  function automatic logic [31:0] bus_fn(input logic [20:0] a);
    return {a[10:0], a} ^ 32'h5A5A_0F0F;
  endfunction

  assign mmio_rd_data = mmio_rd ? bus_fn(mmio_addr) : 32'hDEAD_BEEF;
  assign rsp_ready    = rdy_force ? rdy_val : rdy_rand;

  always @(posedge clk) rdy_rand <= ($urandom % 3) != 0;

  typedef struct { logic wr; logic [20:0] addr; logic [31:0] data; logic first; } bus_t;
  typedef struct { logic [31:0] rdata; logic last; } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0, n_err = 0;
  int   cyc = 0, bus_cnt = 0, rsp_hs = 0, last_bus_cyc = 0;
  bit   chk_cadence = 0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // reference model: a command expands into bus beats and responses by rule
  task automatic model_push(input logic wr, input logic [20:0] a, input logic [31:0] d,
                            input logic [3:0] len);
    if (wr) begin
      bus_q.push_back('{wr: 1'b1, addr: a, data: d, first: 1'b1});
`ifdef FPRO_MASTER_WR_ACK_EN
      rsp_q.push_back('{rdata: 32'h0, last: 1'b1});
`endif
    end else begin
      for (int b = 0; b <= int'(len); b++) begin
        logic [20:0] ba;
        ba = {a[20:5], 5'((int'(a[4:0]) + b) % 32)};
        bus_q.push_back('{wr: 1'b0, addr: ba, data: 32'h0, first: (b == 0)});
        rsp_q.push_back('{rdata: bus_fn(ba), last: (b == int'(len))});
      end
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [20:0] a, input logic [31:0] d,
                          input logic [3:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_len = len;
    while (!cmd_ready && t < 2000) begin step(); t++; end
    if (!cmd_ready) begin
      chk("push_timeout", 1'b0, 64'(t), 64'd2000);
      cmd_valid = 1'b0;
      return;
    end
    model_push(wr, a, d, len);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || busy) && t < 3000) begin step(); t++; end
    chk(nm, t < 3000, 64'(bus_q.size() + rsp_q.size()), 64'd0);
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (mmio_cs) begin
          bus_t e;
          chk("bus_one_strobe", mmio_wr ^ mmio_rd, {62'h0, mmio_wr, mmio_rd}, 64'h1);
          chk("bus_while_rsp_pending", !rsp_valid, 64'(rsp_valid), 64'h0);
          if (bus_q.size() == 0) begin
            chk("bus_unexpected", 1'b0, 64'(mmio_addr), 64'h0);
          end else begin
            e = bus_q.pop_front();
            chk("bus_wr", mmio_wr == e.wr, 64'(mmio_wr), 64'(e.wr));
            chk("bus_addr", mmio_addr == e.addr, 64'(mmio_addr), 64'(e.addr));
            if (e.wr) chk("bus_wdata", mmio_wr_data == e.data, 64'(mmio_wr_data), 64'(e.data));
            if (chk_cadence && !e.wr && !e.first)
              chk("read_cadence", cyc - last_bus_cyc == 2, 64'(cyc - last_bus_cyc), 64'd2);
          end
          bus_cnt++;
          last_bus_cyc = cyc;
        end else begin
          chk("strobes_idle", !mmio_wr && !mmio_rd, {62'h0, mmio_wr, mmio_rd}, 64'h0);
        end
        if (prev_stall) begin
          chk("rsp_hold_valid", rsp_valid, 64'(rsp_valid), 64'h1);
          chk("rsp_hold_data", rsp_rdata == prev_rdata && rsp_last == prev_last,
              {31'h0, rsp_last, rsp_rdata}, {31'h0, prev_last, prev_rdata});
        end
        if (rsp_valid && rsp_ready) begin
          rsp_t r;
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 1'b0, 64'(rsp_rdata), 64'h0);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata == r.rdata, 64'(rsp_rdata), 64'(r.rdata));
            chk("rsp_last", rsp_last == r.last, 64'(rsp_last), 64'(r.last));
          end
          rsp_hs++;
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rdata = rsp_rdata;
        prev_last  = rsp_last;
      end
    end
  endtask

  initial begin
    int base, t;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
    fork monitor(); join_none
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready == 1'b0, 64'(cmd_ready), 64'h0);
    chk("rst_rsp", !rsp_valid && !rsp_last && rsp_rdata == 0, {31'h0, rsp_valid, rsp_rdata}, 64'h0);
    chk("rst_busy", busy == 1'b0, 64'(busy), 64'h0);
    chk("rst_mmio", !mmio_cs && !mmio_wr && !mmio_rd && mmio_addr == 0 && mmio_wr_data == 0,
        {mmio_addr, mmio_wr_data}, 64'h0);
    reset = 1'b0;
    step();
    chk("cmd_ready_after_rst", cmd_ready == 1'b1, 64'(cmd_ready), 64'h1);

    // write then single-beat read to the same register
    push_cmd(1'b1, 21'h0A1, 32'h0000_0001, 4'd0);
    push_cmd(1'b0, 21'h0A1, 32'h0, 4'd0);
    wait_drain("drain_wr_rd");

    // wrapping burst with rsp_ready held high: one beat every 2 cycles
    chk_cadence = 1'b1;
    push_cmd(1'b0, 21'h0BE, 32'h0, 4'd3);
    wait_drain("drain_wrap");
    chk_cadence = 1'b0;

    // 16-beat burst, stall five cycles on beat 2
    base = rsp_hs;
    push_cmd(1'b0, 21'h1F3E5, 32'h0, 4'd15);
    t = 0;
    while (!(rsp_valid && rsp_hs == base + 1) && t < 200) begin step(); t++; end
    chk("stall_reach_beat2", t < 200, 64'(t), 64'd200);
    rdy_val = 1'b0;
    begin
      int bc;
      bc = bus_cnt;
      repeat (5) step();
      chk("no_bus_while_stalled", bus_cnt == bc, 64'(bus_cnt), 64'(bc));
    end
    rdy_val = 1'b1;
    wait_drain("drain_stall");
    chk("burst16_beats", rsp_hs == base + 16, 64'(rsp_hs - base), 64'd16);

    // long stalled read blocks the bus while six writes queue up
    rdy_val = 1'b0;
    push_cmd(1'b0, 21'h00420, 32'h0, 4'd15);
    step();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 21'h00100 + 21'(i), 32'hC0DE_0000 + 32'(i), 4'd0);
    chk("fifo_full_ready_low", cmd_ready == 1'b0, 64'(cmd_ready), 64'h0);
    chk("fifo_full_busy", busy == 1'b1, 64'(busy), 64'h1);
    rdy_val = 1'b1;
    for (int i = 4; i < 6; i++) push_cmd(1'b1, 21'h00100 + 21'(i), 32'hC0DE_0000 + 32'(i), 4'd0);
    wait_drain("drain_fill");

    // reset in the middle of a burst
    base = bus_cnt;
    push_cmd(1'b0, 21'h0033C, 32'h0, 4'd7);
    t = 0;
    while (bus_cnt < base + 1 && t < 100) begin step(); t++; end
    chk("reach_beat1", t < 100, 64'(t), 64'd100);
    reset = 1'b1;
    step();
    chk("midrst_cmd_ready", cmd_ready == 1'b0, 64'(cmd_ready), 64'h0);
    bus_q.delete();
    rsp_q.delete();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_rsp_valid", rsp_valid == 1'b0, 64'(rsp_valid), 64'h0);
    chk("post_rst_busy", busy == 1'b0, 64'(busy), 64'h0);
    chk("post_rst_cmd_ready", cmd_ready == 1'b1, 64'(cmd_ready), 64'h1);
    repeat (10) step();
    chk("post_rst_quiet", !mmio_cs && !busy, {62'h0, mmio_cs, busy}, 64'h0);

    // lone write: ack response, or idle shortly after acceptance
    push_cmd(1'b1, 21'h0A0, 32'h1234_5678, 4'd0);
`ifdef FPRO_MASTER_WR_ACK_EN
    wait_drain("drain_wr_ack");
`else
    step(); step();
    chk("wr_noack_busy_low", busy == 1'b0, 64'(busy), 64'h0);
    chk("wr_noack_no_rsp", rsp_valid == 1'b0, 64'(rsp_valid), 64'h0);
`endif

    // randomized traffic with random back-pressure
    rdy_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [20:0] a;
      w = ($urandom % 3) == 0;
      a = 21'($urandom);
      if ($urandom % 2) a[4:0] = 5'd28 + 5'($urandom % 4);
      push_cmd(w, a, $urandom, 4'($urandom % 6));
      if ($urandom % 4 == 0) repeat ($urandom % 4) step();
    end
    wait_drain("drain_random");
    rdy_force = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fpro_bus_master.md
FPRO_BUS_MASTER -- requirements
Module: fpro_bus_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; transfer when both high on a rising edge.
REQ-005 cmd_wr  input  1  1 = write, 0 = read.
REQ-006 cmd_addr  input  21  FPro word address: [10:5] slot, [4:0] register.
REQ-007 cmd_wdata  input  32  write data; ignored for reads.
REQ-008 cmd_len  input  4  read burst beats minus 1 (0 = 1 beat, 15 = 16 beats); ignored for writes.
REQ-009 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-010 rsp_rdata  output  32  captured read data.
REQ-011 rsp_last  output  1  final beat of a command.
REQ-012 busy  output  1  FIFO non-empty, FSM not IDLE, or rsp_valid high.
REQ-013 mmio_cs, mmio_wr, mmio_rd  output  1 each  FPro bus strobes, registered.
REQ-014 mmio_addr  output  21  registered bus address.
REQ-015 mmio_wr_data  output  32  registered bus write data.
REQ-016 mmio_rd_data  input  32  bus read data, valid during the cycle mmio_rd is high.

Function
REQ-017 Commands SHALL enter a FIFO_DEPTH-entry FIFO; cmd_ready = FIFO not full; accepted command visible to the FSM on the next cycle.
REQ-018 Push while full SHALL be impossible (cmd_ready low); simultaneous push and pop when full SHALL be refused, pop proceeds.
REQ-019 FSM states IDLE, WRITE, READ, WAIT_RSP; IDLE pops head when FIFO non-empty.
REQ-020 Write: one bus cycle with mmio_cs=mmio_wr=1, mmio_rd=0, addr/data from command; back-to-back writes SHALL occupy consecutive cycles.
REQ-021 Read beat: one bus cycle with mmio_cs=mmio_rd=1, mmio_wr=0; mmio_rd_data captured on that cycle's closing edge into rsp_rdata, rsp_valid high next cycle.
REQ-022 Next read beat SHALL launch only after current beat's response handshake; rsp_ready held 1 gives one beat every 2 cycles.
REQ-023 Burst address SHALL increment addr[4:0] by 1 per beat, wrapping 31->0; addr[20:5] unchanged.
REQ-024 rsp_last SHALL be 1 only on the beat numbered cmd_len.
REQ-025 rsp_valid/rsp_rdata/rsp_last SHALL hold stable while rsp_valid && !rsp_ready.
REQ-026 Outside a bus cycle mmio_cs, mmio_wr, mmio_rd SHALL be 0; mmio_addr/mmio_wr_data hold last value.
REQ-027 At most one bus strobe (wr or rd) SHALL be high per cycle.

Reset
REQ-028 Reset SHALL empty the FIFO, abort any burst, return FSM to IDLE.
REQ-029 Reset values: cmd_ready=0 during reset, 1 the cycle after; rsp_valid=0, rsp_last=0, rsp_rdata=0, busy=0, mmio_cs/wr/rd=0, mmio_addr=0, mmio_wr_data=0.
REQ-030 Reset asserted mid-burst SHALL suppress all remaining beats and any pending response.

Configuration
REQ-031 Macro FPRO_MASTER_WR_ACK_EN defined: each write SHALL produce one response (rsp_rdata=0, rsp_last=1) one cycle after its bus cycle; next command waits for its handshake.
REQ-032 Macro undefined: writes SHALL produce no response and no ack logic SHALL be synthesized.

Verification
REQ-033 Write 0xA1/0x0000_0001 then read 0xA1 len 0 -> bus write cycle then read cycle; one response with rsp_last=1, data from bus model.
REQ-034 Read 0xBE len 3, rsp_ready=1 -> bus addrs 0xBE,0xBF,0xA0,0xA1, one every 2 cycles; rsp_last on 4th beat only.
REQ-035 Read len 15 with rsp_ready low for 5 cycles on beat 2 -> no bus cycle while stalled; rsp_rdata stable; 16 beats total.
REQ-036 Push 6 writes with bus idle-blocked by a long read ahead -> cmd_ready drops after FIFO full; all 6 writes later issue in order.
REQ-037 Reset asserted after beat 1 of a len 7 read -> no further bus strobes, rsp_valid=0, busy=0 the cycle after reset releases.
REQ-038 With FPRO_MASTER_WR_ACK_EN: write 0xA0 -> response rsp_rdata=0, rsp_last=1; without: no response, busy low 2 cycles after acceptance.
